fu_issue_sched: RTL

FU_ISSUE_SCHED -- requirements
Module: fu_issue_sched

---
 rtl/fu_issue_sched.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fu_issue_sched.sv
// Functional-unit issue scheduler: picks the oldest ready RS slot whose unit is free
// and registers it into a single issue slot, tracking MULT and LS occupancy.
package fu_issue_pkg;
    typedef enum logic [1:0] {ALU = 2'd0, LS = 2'd1, MULT = 2'd2, BRANCH = 2'd3} FUNC_UNIT;
endpackage

module fu_slot_elig
    import fu_issue_pkg::*;
(
    input  logic     ready,
    input  FUNC_UNIT func,
    input  logic     alu_free,
    input  logic     mult_free,
    input  logic     ls_free,
    output logic     elig
);
    always_comb begin
        elig = 1'b0;
        case (func)
            ALU:     elig = ready & alu_free;
            LS:      elig = ready & ls_free;
            MULT:    elig = ready & mult_free;
            BRANCH:  elig = ready;
            default: elig = 1'b0;
        endcase
    end
endmodule

module fu_issue_sched
    import fu_issue_pkg::*;
#(
    parameter  int RS_SIZE  = 16,
    parameter  int MULT_LAT = 4,
    localparam int IDX_W    = $clog2(RS_SIZE)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic     [RS_SIZE-1:0]     rs_ready,
    input  FUNC_UNIT [RS_SIZE-1:0]     rs_func,
    input  logic                       alu_stall_in,
    input  logic                       ls_done_in,
    input  logic                       squash,
    input  logic                       issue_ready,
    output logic     [RS_SIZE-1:0]     gnt,
    output logic                       issue_valid,
    output logic     [IDX_W-1:0]       issue_idx,
    output FUNC_UNIT                   issue_func,
    output logic                       mult_busy,
    output logic                       ls_busy
);
    localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT);

    logic [3:0]         mult_cnt;
    logic [RS_SIZE-1:0] eligible;
    logic [IDX_W-1:0]   gnt_idx;
    logic               found;
    logic               can_grant;
    logic               grant_any;
    FUNC_UNIT           gnt_func;

    assign mult_busy = (mult_cnt != 4'd0);

    for (genvar k = 0; k < RS_SIZE; k++) begin : g_slot
        fu_slot_elig u_elig (
            .ready     (rs_ready[k]),
            .func      (rs_func[k]),
            .alu_free  (!alu_stall_in),
            .mult_free (!mult_busy),
            .ls_free   (!ls_busy),
            .elig      (eligible[k])
        );
    end

    // Reset is folded in so no grant leaks out during a reset cycle.
    assign can_grant = !reset && !squash && !(issue_valid && !issue_ready);

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < RS_SIZE; k++) begin
            if (!found && eligible[k]) begin
                found   = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (can_grant && found)
            gnt[gnt_idx] = 1'b1;
    end

    assign grant_any = can_grant && found;
    assign gnt_func  = rs_func[gnt_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            issue_valid <= 1'b0;
            issue_idx   <= '0;
            issue_func  <= ALU;
            mult_cnt    <= 4'd0;
            ls_busy     <= 1'b0;
        end else begin
            if (grant_any) begin
                issue_valid <= 1'b1;
                issue_idx   <= gnt_idx;
                issue_func  <= gnt_func;
            end else if (squash || issue_ready) begin
                issue_valid <= 1'b0;
            end

            // Units are reserved at grant, even if the issue register is stalled.
            if (grant_any && gnt_func == MULT)
                mult_cnt <= MULT_LOAD;
            else if (mult_cnt != 4'd0)
                mult_cnt <= mult_cnt - 4'd1;

            if (grant_any && gnt_func == LS)
                ls_busy <= 1'b1;
            else if (ls_done_in)
                ls_busy <= 1'b0;
        end
    end
endmodule
